// File: rtl/fifo_rd_ctrl_v2_if.sv
// Read-side FIFO control bus: request/pointer inputs from the consumer and
// synchroniser, status/address outputs from the read controller.
interface fifo_rd_ctrl_v2_if #(
  parameter int unsigned AW = 7
);
  logic          rd_en;
  logic [AW:0]   wr_ptr;
  logic          underflow_clr;
  logic [AW-1:0] rd_addr;
  logic [AW:0]   rd_ptr;
  logic          rd_valid;
  logic          empty;
  logic          almost_empty;
  logic [AW:0]   rd_count;
  logic          underflow;
  logic          underflow_sticky;

  modport master (
    output rd_en, wr_ptr, underflow_clr,
    input  rd_addr, rd_ptr, rd_valid, empty, almost_empty, rd_count,
           underflow, underflow_sticky
  );

  modport slave (
    input  rd_en, wr_ptr, underflow_clr,
    output rd_addr, rd_ptr, rd_valid, empty, almost_empty, rd_count,
           underflow, underflow_sticky
  );
endinterface

// File: rtl/fifo_rd_ctrl_v2.sv
// FIFO read-pointer controller: {wrap,index} pointer for arbitrary depth,
// optional Gray export/import, occupancy, almost-empty and underflow status.
module fifo_rd_ctrl_v2 #(
  parameter int unsigned AW        = 7,
  parameter int unsigned DEPTH     = 90,
  parameter int unsigned AE_THRESH = 2,
  parameter int unsigned PTR_GRAY  = 0
) (
  input  logic               rd_clk,
  input  logic               rd_rst_n,
  fifo_rd_ctrl_v2_if.slave   bus
);
  localparam int unsigned PW       = AW + 1;
  localparam logic [AW:0]   DEPTH_W  = PW'(DEPTH);
  localparam logic [AW:0]   AE_W     = PW'(AE_THRESH);
  localparam logic [AW-1:0] IDX_LAST = AW'(DEPTH - 1);

  // Parameter legality is enforced at elaboration.
  if (DEPTH < 2 || DEPTH > (1 << AW)) begin : g_bad_depth
    $fatal(1, "fifo_rd_ctrl_v2: DEPTH out of range");
  end
  if (AE_THRESH >= DEPTH) begin : g_bad_ae
    $fatal(1, "fifo_rd_ctrl_v2: AE_THRESH must be below DEPTH");
  end
  if (PTR_GRAY != 0 && DEPTH != (1 << AW)) begin : g_bad_gray
    $fatal(1, "fifo_rd_ctrl_v2: Gray pointers need DEPTH == 2**AW");
  end

  logic          rp_wrap, rp_wrap_nxt;
  logic [AW-1:0] rp_idx, rp_idx_nxt;
  logic [AW:0]   rp_nxt;
  logic [AW:0]   rd_ptr_q, rd_ptr_nxt;
  logic          rd_valid_q, underflow_q, sticky_q;
  logic [AW:0]   wp;
  logic [AW:0]   rd_count_c;
  logic          empty_c, almost_empty_c, accept_c, reject_c;

  // Write pointer into binary; Gray decode is a suffix XOR-reduction.
  if (PTR_GRAY != 0) begin : g_wp_gray
    for (genvar i = 0; i <= AW; i++) begin : g_bit
      assign wp[i] = ^bus.wr_ptr[AW:i];
    end
  end else begin : g_wp_bin
    assign wp = bus.wr_ptr;
  end

  always_comb begin
    rd_count_c = '0;
    if (wp[AW] == rp_wrap) rd_count_c = PW'(wp[AW-1:0]) - PW'(rp_idx);
    else                   rd_count_c = DEPTH_W - PW'(rp_idx) + PW'(wp[AW-1:0]);
  end

  assign empty_c        = (rd_count_c == '0);
  assign almost_empty_c = (rd_count_c <= AE_W);
  assign accept_c       = bus.rd_en && !empty_c;
  assign reject_c       = bus.rd_en && empty_c;

  // Index wraps at DEPTH-1; the >= keeps it in range even on a bad wr_ptr.
  always_comb begin
    rp_wrap_nxt = rp_wrap;
    rp_idx_nxt  = rp_idx;
    if (accept_c) begin
      if (rp_idx >= IDX_LAST) begin
        rp_idx_nxt  = '0;
        rp_wrap_nxt = ~rp_wrap;
      end else begin
        rp_idx_nxt = rp_idx + AW'(1);
      end
    end
  end

  assign rp_nxt     = {rp_wrap_nxt, rp_idx_nxt};
  assign rd_ptr_nxt = (PTR_GRAY != 0) ? (rp_nxt ^ (rp_nxt >> 1)) : rp_nxt;

  always_ff @(posedge rd_clk) begin
    if (!rd_rst_n) begin
      rp_wrap     <= 1'b0;
      rp_idx      <= '0;
      rd_ptr_q    <= '0;
      rd_valid_q  <= 1'b0;
      underflow_q <= 1'b0;
      sticky_q    <= 1'b0;
    end else begin
      rp_wrap     <= rp_wrap_nxt;
      rp_idx      <= rp_idx_nxt;
      rd_ptr_q    <= rd_ptr_nxt;
      rd_valid_q  <= accept_c;
      underflow_q <= reject_c;
      if (reject_c)               sticky_q <= 1'b1;
      else if (bus.underflow_clr) sticky_q <= 1'b0;
    end
  end

  assign bus.rd_addr          = rp_idx;
  assign bus.rd_ptr           = rd_ptr_q;
  assign bus.rd_valid         = rd_valid_q;
  assign bus.empty            = empty_c;
  assign bus.almost_empty     = almost_empty_c;
  assign bus.rd_count         = rd_count_c;
  assign bus.underflow        = underflow_q;
  assign bus.underflow_sticky = sticky_q;
endmodule

// File: tb/tb_fifo_rd_ctrl_v2.sv
// Directed bench for fifo_rd_ctrl_v2: binary DEPTH=90 instance against a
// linear-position model with an address scoreboard, plus a Gray DEPTH=16 instance.
module tb_fifo_rd_ctrl_v2;
  localparam int unsigned AW = 7, DEPTH = 90, AE = 2;
  localparam int unsigned GAW = 4, GDEPTH = 16;

  logic rd_clk = 1'b0;
  logic rd_rst_n = 1'b0;
  logic g_rst_n = 1'b0;
  always #5 rd_clk = ~rd_clk;

  fifo_rd_ctrl_v2_if #(.AW(AW))  bus ();
  fifo_rd_ctrl_v2_if #(.AW(GAW)) gbus ();

  fifo_rd_ctrl_v2 #(.AW(AW), .DEPTH(DEPTH), .AE_THRESH(AE), .PTR_GRAY(0)) u_dut (
    .rd_clk(rd_clk), .rd_rst_n(rd_rst_n), .bus(bus.slave));
  fifo_rd_ctrl_v2 #(.AW(GAW), .DEPTH(GDEPTH), .AE_THRESH(AE), .PTR_GRAY(1)) u_gray (
    .rd_clk(rd_clk), .rd_rst_n(g_rst_n), .bus(gbus.slave));

  int checks = 0;
  int failures = 0;

  int unsigned m_wrap, m_idx;
  logic m_valid, m_uf, m_sticky;
  int unsigned exp_q[$];
  int unsigned obs_addr;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Occupancy from linear positions modulo 2*DEPTH.
  function automatic int unsigned occ();
    int lw, lr;
    lw = int'(bus.wr_ptr[AW]) * DEPTH + int'(bus.wr_ptr[AW-1:0]);
    lr = int'(m_wrap) * DEPTH + int'(m_idx);
    return int'((lw - lr + 2 * DEPTH) % (2 * DEPTH));
  endfunction

  task automatic check_all();
    int unsigned c;
    c = occ();
    check("rd_addr", 32'(bus.rd_addr), m_idx);
    check("rd_ptr", 32'(bus.rd_ptr), m_wrap * 128 + m_idx);
    check("rd_count", 32'(bus.rd_count), c);
    check("empty", 32'(bus.empty), 32'(c == 0));
    check("almost_empty", 32'(bus.almost_empty), 32'(c <= AE));
    check("rd_valid", 32'(bus.rd_valid), 32'(m_valid));
    check("underflow", 32'(bus.underflow), 32'(m_uf));
    check("underflow_sticky", 32'(bus.underflow_sticky), 32'(m_sticky));
    if (bus.rd_valid === 1'b1) begin
      if (exp_q.size() == 0) check("sb_unexpected_valid", 32'(1), 32'(0));
      else check("sb_rd_addr", obs_addr, exp_q.pop_front());
    end
  endtask

  // One clock with the inputs currently driven; model updates, then checks at negedge.
  task automatic tick();
    int unsigned c;
    bit acc, rej;
    c = occ();
    acc = (bus.rd_en === 1'b1) && (c != 0);
    rej = (bus.rd_en === 1'b1) && (c == 0);
    if (acc) obs_addr = 32'(bus.rd_addr);
    @(posedge rd_clk);
    if (!rd_rst_n) begin
      m_wrap = 0; m_idx = 0; m_valid = 1'b0; m_uf = 1'b0; m_sticky = 1'b0;
      exp_q.delete();
    end else begin
      if (acc) begin
        exp_q.push_back(m_idx);
        m_idx++;
        if (m_idx == DEPTH) begin m_idx = 0; m_wrap ^= 1; end
      end
      m_valid = acc;
      m_uf = rej;
      if (rej) m_sticky = 1'b1;
      else if (bus.underflow_clr) m_sticky = 1'b0;
    end
    @(negedge rd_clk);
    check_all();
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    logic [GAW:0] prev_g, exp_g;
    m_wrap = 0; m_idx = 0; m_valid = 1'b0; m_uf = 1'b0; m_sticky = 1'b0;
    obs_addr = 0;
    bus.rd_en = 1'b0; bus.wr_ptr = '0; bus.underflow_clr = 1'b0;
    gbus.rd_en = 1'b0; gbus.wr_ptr = '0; gbus.underflow_clr = 1'b0;

    // Reset
    @(negedge rd_clk);
    ticks(2);
    check("rst_empty", 32'(bus.empty), 32'(1));
    check("rst_rd_ptr", 32'(bus.rd_ptr), 32'(0));

    // Drain five entries then one rejected read
    rd_rst_n = 1'b1;
    bus.wr_ptr = {1'b0, AW'(5)};
    bus.rd_en = 1'b1;
    ticks(6);
    check("drain_underflow_pulse", 32'(bus.underflow), 32'(1));
    bus.rd_en = 1'b0;
    tick();
    check("drain_rd_ptr", 32'(bus.rd_ptr), 32'(5));
    check("drain_sticky", 32'(bus.underflow_sticky), 32'(1));
    bus.underflow_clr = 1'b1;
    tick();
    bus.underflow_clr = 1'b0;
    check("clr_sticky", 32'(bus.underflow_sticky), 32'(0));

    // Reject and clear in the same cycle: set wins
    bus.rd_en = 1'b1; bus.underflow_clr = 1'b1;
    tick();
    bus.rd_en = 1'b0; bus.underflow_clr = 1'b0;
    check("set_wins_sticky", 32'(bus.underflow_sticky), 32'(1));

    // Advance to index 88, then wrap through DEPTH-1
    bus.wr_ptr = {1'b0, AW'(88)};
    bus.rd_en = 1'b1;
    ticks(83);
    bus.rd_en = 1'b0;
    tick();
    check("pre_wrap_addr", 32'(bus.rd_addr), 32'(88));
    bus.wr_ptr = {1'b1, AW'(3)};
    tick();
    check("wrap_count", 32'(bus.rd_count), 32'(5));
    bus.rd_en = 1'b1;
    ticks(5);
    bus.rd_en = 1'b0;
    tick();
    check("wrap_rd_ptr", 32'(bus.rd_ptr), 32'(128 + 3));
    check("wrap_empty", 32'(bus.empty), 32'(1));

    // Almost-empty threshold crossing
    bus.wr_ptr = {1'b1, AW'(6)};
    tick();
    check("ae_cnt3", 32'(bus.almost_empty), 32'(0));
    bus.rd_en = 1'b1;
    tick();
    check("ae_cnt2", 32'(bus.almost_empty), 32'(1));
    check("ae_cnt2_empty", 32'(bus.empty), 32'(0));
    ticks(2);
    check("ae_drained", 32'(bus.empty), 32'(1));
    bus.rd_en = 1'b0;
    tick();

    // Reset while streaming
    bus.wr_ptr = {1'b1, AW'(50)};
    bus.rd_en = 1'b1;
    ticks(34);
    check("stream_rd_ptr", 32'(bus.rd_ptr), 32'(128 + 40));
    check("stream_valid", 32'(bus.rd_valid), 32'(1));
    rd_rst_n = 1'b0;
    tick();
    check("midrst_rd_ptr", 32'(bus.rd_ptr), 32'(0));
    check("midrst_valid", 32'(bus.rd_valid), 32'(0));
    tick();
    check("midrst_hold", 32'(bus.rd_addr), 32'(0));
    bus.rd_en = 1'b0;
    bus.wr_ptr = '0;
    rd_rst_n = 1'b1;
    tick();

    // Gray instance: full FIFO, 16 reads, one bit changes per step
    g_rst_n = 1'b1;
    gbus.wr_ptr = 5'b11000;
    @(negedge rd_clk);
    check("gray_full_count", 32'(gbus.rd_count), 32'(16));
    prev_g = gbus.rd_ptr;
    gbus.rd_en = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      @(posedge rd_clk);
      @(negedge rd_clk);
      exp_g = 5'(k) ^ (5'(k) >> 1);
      check("gray_rd_ptr", 32'(gbus.rd_ptr), 32'(exp_g));
      check("gray_one_bit", 32'($countones(gbus.rd_ptr ^ prev_g)), 32'(1));
      check("gray_count", 32'(gbus.rd_count), 32'(16 - k));
      prev_g = gbus.rd_ptr;
    end
    check("gray_empty", 32'(gbus.empty), 32'(1));
    @(posedge rd_clk);
    @(negedge rd_clk);
    gbus.rd_en = 1'b0;
    check("gray_underflow", 32'(gbus.underflow), 32'(1));
    check("gray_hold", 32'(gbus.rd_ptr), 32'(5'b11000));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/fifo_rd_ctrl_v2.md
Name: fifo_rd_ctrl_v2

Overview:
Parametrised read-side controller for the team's FIFOs, one generation on from the single-depth read-pointer/empty block. Keeps the {wrap, index} pointer scheme and supports any depth up to 2**AW. New in this generation: optional Gray pointer encoding for CDC, an occupancy count, almost-empty, registered read-valid aligned to synchronous RAM, and underflow reporting. Sits between the write-pointer synchroniser and the FIFO RAM read port, all in the read clock domain.

Parameters:
AW, 7, index width; RAM address width.
DEPTH, 90, number of entries; 2 <= DEPTH <= 2**AW.
AE_THRESH, 2, almost_empty asserts when occupancy <= AE_THRESH; 0 <= AE_THRESH < DEPTH.
PTR_GRAY, 0, 0 = pointers are binary {wrap,index}; 1 = pointers are Gray of binary {wrap,index}, and DEPTH must equal 2**AW.

Ports:
rd_clk  in  1  read clock; all logic on its rising edge.
rd_rst_n  in  1  synchronous, active-low reset.
rd_en  in  1  read request.
wr_ptr  in  AW+1  write pointer, already synchronised into rd_clk; encoded per PTR_GRAY.
underflow_clr  in  1  clears underflow_sticky.
rd_addr  out  AW  RAM read address; the current read index.
rd_ptr  out  AW+1  read pointer for export to the write side; encoded per PTR_GRAY.
rd_valid  out  1  RAM data for the last accepted read is valid this cycle.
empty  out  1  occupancy == 0.
almost_empty  out  1  occupancy <= AE_THRESH.
rd_count  out  AW+1  occupancy, 0..DEPTH.
underflow  out  1  one-cycle pulse on a rejected read.
underflow_sticky  out  1  latched underflow.

Behaviour:
- Internal state: binary pointer rp = {rp_wrap, rp_idx}, rd_valid register, underflow register, underflow_sticky register.
- Reset (rd_rst_n = 0 at a rising edge): rp = 0, rd_valid = 0, underflow = 0, underflow_sticky = 0. Reset overrides every other input, including mid-read.
- wr_ptr decode: if PTR_GRAY = 1, Gray-to-binary into wp = {wp_wrap, wp_idx}; otherwise use it directly. rd_ptr = rp, or its Gray encoding (rp ^ (rp >> 1)) when PTR_GRAY = 1.
- Occupancy (combinational): if wp_wrap == rp_wrap, rd_count = wp_idx - rp_idx; otherwise rd_count = DEPTH - rp_idx + wp_idx. Compute at AW+1 bits with no truncation.
- empty = (rd_count == 0); almost_empty = (rd_count <= AE_THRESH). Both are combinational from rp and wr_ptr, with zero-cycle latency, so they must not depend on rd_en.
- Accept = rd_en && !empty.
  - On accept, if rp_idx == DEPTH-1: rp_idx <= 0 and rp_wrap <= ~rp_wrap.
  - On accept otherwise: rp_idx <= rp_idx + 1, wrap unchanged.
- rd_addr = rp_idx, the pre-increment value during the accepting cycle. rd_valid <= accept, so it is high exactly one cycle after each accept (1-cycle RAM latency). Back-to-back accepts give continuous rd_valid.
- Reject = rd_en && empty.
  - Pointer is held.
  - underflow <= 1 for one cycle.
  - underflow_sticky <= 1.
- underflow_sticky <= 0 when underflow_clr = 1 and no reject occurs in that cycle. If both happen in the same cycle, set wins.
- No accept occurs when rd_en = 0; the pointer holds.
- rd_count never exceeds DEPTH given a legal wr_ptr. Behaviour for an illegal wr_ptr (index >= DEPTH) is undefined, but the pointer must still never leave 0..DEPTH-1.
- Illegal parameters (DEPTH > 2**AW, AE_THRESH >= DEPTH, PTR_GRAY = 1 with DEPTH != 2**AW) must fail at elaboration.

Test Plan:
1. Reset: AW=7, DEPTH=90, wr_ptr=0, rd_rst_n low for 2 cycles -> rd_ptr=0, rd_addr=0, empty=1, almost_empty=1, rd_count=0, rd_valid=0, underflow_sticky=0.
2. Drain plus underflow: wr_ptr={0,5}, rd_en high for 6 cycles -> rd_addr 0,1,2,3,4 on accepts; rd_valid high cycles 2-6; rd_count 5→0. Cycle 6 rejected: underflow pulses once, sticky=1, rd_ptr stays {0,5}. underflow_clr for 1 cycle -> sticky=0.
3. Wrap at non-power-of-2 depth: rp={0,88}, wr_ptr={1,3} -> rd_count=5. Five reads give rd_addr 88,89,0,1,2; final rd_ptr={1,3}, empty=1.
4. Thresholds with AE_THRESH=2: rd_count 3 -> almost_empty=0; after one read, rd_count=2 -> almost_empty=1, empty=0; after two more reads -> empty=1.
5. Gray mode, AW=4, DEPTH=16: wr_ptr=Gray(16)=5'b11000 -> rd_count=16. 16 reads -> rd_ptr=5'b11000, empty=1, and each rd_ptr step changes exactly one bit.
6. Reset mid-operation: during a streaming read with rd_valid=1 and rp={1,40}, assert rd_rst_n=0 -> next edge rp=0, rd_valid=0, underflow=0; rd_en ignored while in reset.
